// File: rtl/tx_data_buffer.sv
// rtl/tx_data_buffer.sv - 64x8 circular TX byte FIFO with FWFT head; optional sticky error flags (TX_BUF_ERR_FLAGS_EN)
module tx_data_buffer (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       store_tx_data,
   input  logic       get_tx_packet_data,
   input  logic       flush,
   input  logic       clear,
   output logic [7:0] tx_packet_data,
   output logic [6:0] buffer_occupancy,
   output logic       overrun_err,
   output logic       underrun_err
);

   localparam int unsigned DEPTH = 64;

   logic [7:0] mem_q [0:DEPTH-1];
   logic [5:0] wr_ptr_q, wr_ptr_d;
   logic [5:0] rd_ptr_q, rd_ptr_d;
   logic [6:0] occ_q, occ_d;
   logic       full, empty, discard, do_push, do_pop;

   // Decide which operations take effect this edge; flush/clear overrides everything.
   // A pop while full frees a slot, so a same-cycle push is still accepted.
   always_comb begin
      full     = (occ_q == 7'd64);
      empty    = (occ_q == 7'd0);
      discard  = flush | clear;
      do_pop   = get_tx_packet_data & ~empty & ~discard;
      do_push  = store_tx_data & (~full | get_tx_packet_data) & ~discard;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (discard) begin
         wr_ptr_d = 6'd0;
         rd_ptr_d = 6'd0;
         occ_d    = 7'd0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 6'd1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 6'd1;
         case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 7'd1;
            2'b01:   occ_d = occ_q - 7'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= 6'd0;
         rd_ptr_q <= 6'd0;
         occ_q    <= 7'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage array; contents are never cleared, only the pointers are.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= tx_data;
   end

   assign tx_packet_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign buffer_occupancy = occ_q;

`ifdef TX_BUF_ERR_FLAGS_EN
   logic ovr_q, ovr_d;
   logic und_q, und_d;

   // Sticky flags: set on a dropped push or an ignored lone pop; flush/clear wins.
   always_comb begin
      ovr_d = ovr_q | (store_tx_data & full & ~get_tx_packet_data);
      und_d = und_q | (get_tx_packet_data & empty & ~store_tx_data);
      if (discard) begin
         ovr_d = 1'b0;
         und_d = 1'b0;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ovr_q <= 1'b0;
         und_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
         und_q <= und_d;
      end
   end

   assign overrun_err  = ovr_q;
   assign underrun_err = und_q;
`else
   assign overrun_err  = 1'b0;
   assign underrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_data_buffer.sv
// tb/tb_tx_data_buffer.sv - scoreboard bench for tx_data_buffer with a queue-based reference model
module tb_tx_data_buffer;

`ifdef TX_BUF_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       store_tx_data = 1'b0;
   logic       get_tx_packet_data = 1'b0;
   logic       flush = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       overrun_err;
   logic       underrun_err;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: exp_q holds the bytes expected to leave the FIFO, in order
   logic [7:0] exp_q[$];
   int         ref_cnt = 0;
   bit         ref_ovr = 1'b0;
   bit         ref_und = 1'b0;
   logic [7:0] exp_head;
   bit         push_ok, pop_ok;

   tx_data_buffer dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_data            (tx_data),
      .store_tx_data      (store_tx_data),
      .get_tx_packet_data (get_tx_packet_data),
      .flush              (flush),
      .clear              (clear),
      .tx_packet_data     (tx_packet_data),
      .buffer_occupancy   (buffer_occupancy),
      .overrun_err        (overrun_err),
      .underrun_err       (underrun_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   // Reference model: applies the buffer rules at each edge using the pre-edge inputs.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst || flush || clear) begin
         ref_cnt = 0;
         exp_q.delete();
         ref_ovr = 1'b0;
         ref_und = 1'b0;
      end else begin
         pop_ok  = get_tx_packet_data && ref_cnt > 0;
         push_ok = store_tx_data && (ref_cnt < 64 || get_tx_packet_data);
         if (ERR_EN && store_tx_data && ref_cnt == 64 && !get_tx_packet_data) ref_ovr = 1'b1;
         if (ERR_EN && get_tx_packet_data && ref_cnt == 0 && !store_tx_data) ref_und = 1'b1;
         if (push_ok) exp_q.push_back(tx_data);
         ref_cnt = ref_cnt + int'(push_ok) - int'(pop_ok);
      end
   end

   // Monitor: compares DUT outputs mid-cycle and retires popped bytes from the scoreboard.
   always @(negedge clk) begin
      exp_head = (ref_cnt != 0) ? exp_q[0] : 8'h00;
      check("occupancy", int'(buffer_occupancy), ref_cnt);
      check("head", int'(tx_packet_data), int'(exp_head));
      check("overrun_err", int'(overrun_err), int'(ref_ovr));
      check("underrun_err", int'(underrun_err), int'(ref_und));
      if (n_rst && get_tx_packet_data && !flush && !clear && ref_cnt != 0)
         check("pop_data", int'(tx_packet_data), int'(exp_q.pop_front()));
   end

   task automatic step(input logic s, input logic [7:0] d, input logic g,
                       input logic f = 1'b0, input logic c = 1'b0);
      @(posedge clk);
      #1;
      store_tx_data      = s;
      tx_data            = d;
      get_tx_packet_data = g;
      flush              = f;
      clear              = c;
   endtask

   task automatic idle(input int n = 1);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, then release between edges
      repeat (3) @(posedge clk);
      #3 n_rst = 1'b1;
      idle(2);

      // two pushes, then one pop
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h3C, 1'b0);
      idle(1);
      step(1'b0, 8'h00, 1'b1);
      idle(1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // fill to 64, overflow, push+pop while full, drain
      for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      idle(1);
      step(1'b1, 8'hEE, 1'b1);
      idle(1);
      for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1);
      idle(1);

      // push+pop while empty, then lone pop while empty
      step(1'b1, 8'h11, 1'b1);
      idle(1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      idle(1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // wrap-around at occupancy 10
      for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b1);
      idle(1);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

      // flush and clear with a same-cycle push (and pop)
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
      idle(1);

      // randomized traffic with occasional flush/clear
      for (int i = 0; i < 500; i++)
         step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 2));
      for (int i = 0; i < 70; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

      // asynchronous reset mid-cycle at occupancy 30
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      check("rst_occupancy", int'(buffer_occupancy), 0);
      check("rst_head", int'(tx_packet_data), 0);
      check("rst_overrun", int'(overrun_err), 0);
      check("rst_underrun", int'(underrun_err), 0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      step(1'b1, 8'h77, 1'b0);
      idle(2);
      step(1'b0, 8'h00, 1'b1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 tx_data  input  8  byte written by the host-side (AHB) interface.
REQ-005 store_tx_data  input  1  push tx_data into the buffer this cycle.
REQ-006 get_tx_packet_data  input  1  TX encoder pops the head byte this cycle.
REQ-007 flush  input  1  discard all buffered bytes.
REQ-008 clear  input  1  discard all buffered bytes; same effect as flush.
REQ-009 tx_packet_data  output  8  head byte presented to the TX encoder.
REQ-010 buffer_occupancy  output  7  number of stored bytes, 0..64.
REQ-011 overrun_err  output  1  sticky: push attempted while full.
REQ-012 underrun_err  output  1  sticky: pop attempted while empty.

Function
REQ-013 Storage SHALL be a 64-entry x 8-bit circular FIFO with 6-bit write and read pointers that wrap 63->0.
REQ-014 Occupancy SHALL be a registered 7-bit count; full = 64, empty = 0.
REQ-015 tx_packet_data SHALL be combinational first-word-fall-through: entry at read pointer when occupancy > 0, else 8'h00.
REQ-016 Push, when not full: tx_data written at write pointer, write pointer +1, occupancy +1 at the same edge.
REQ-017 Pop, when not empty: read pointer +1, occupancy -1; the byte is valid on tx_packet_data in the cycle get_tx_packet_data is high.
REQ-018 Push and pop together, not empty and not full: both performed; occupancy unchanged.
REQ-019 Push and pop together while empty: push performed, pop ignored; occupancy becomes 1. The same-cycle byte SHALL NOT fall through.
REQ-020 Push and pop together while full: both performed; occupancy stays 64; no overrun.
REQ-021 Push alone while full: byte dropped; pointers and occupancy unchanged.
REQ-022 Pop alone while empty: ignored; pointers unchanged.
REQ-023 flush or clear: highest priority; at the next edge both pointers and occupancy become 0 and any same-cycle push or pop is ignored.
REQ-024 Storage contents SHALL NOT require clearing on flush/clear; only pointers and occupancy reset.

Reset
REQ-025 n_rst low SHALL immediately force pointers, occupancy, overrun_err and underrun_err to 0, with tx_packet_data = 8'h00.
REQ-026 Reset mid-transfer SHALL discard all contents; the first push after release lands in entry 0.

Configuration
REQ-027 Macro TX_BUF_ERR_FLAGS_EN SHALL gate the error-flag logic.
REQ-028 With TX_BUF_ERR_FLAGS_EN: overrun_err sets on REQ-021 and underrun_err sets on REQ-022; flags are sticky until flush, clear or reset.
REQ-029 Flush/clear SHALL take priority over a same-cycle error set.
REQ-030 Without TX_BUF_ERR_FLAGS_EN: both flag ports SHALL still exist, tied to 0, with no flag registers.

Verification
REQ-031 Reset, then push 8'hA5, 8'h3C -> occupancy 2, tx_packet_data 8'hA5; pop -> 8'h3C, occupancy 1.
REQ-032 Push 64 bytes 0..63, then push 8'hFF -> occupancy 64, 8'hFF dropped, overrun_err 1 (macro on); pop 64 -> bytes 0..63 in order.
REQ-033 Wrap-around: cycle 100 push/pop pairs at occupancy 10 -> occupancy stays 10 and data order is preserved across pointer wrap.
REQ-034 While empty, assert push 8'h11 and pop together -> occupancy 1, tx_packet_data 8'h11 next cycle; pop while empty -> underrun_err 1.
REQ-035 Occupancy 20, assert flush with push -> occupancy 0, tx_packet_data 8'h00, error flags 0; repeat with clear for the same result.
REQ-036 Assert n_rst low asynchronously mid-cycle at occupancy 30 -> outputs 0 immediately; next push 8'h77 -> occupancy 1, head 8'h77.
